// File: rtl/dice_pkg.sv
// Shared definitions for the dice game: FSM state encoding, width helpers
// and the default craps rule sums.
package dice_pkg;

  typedef enum logic [2:0] {
    COME_WAIT  = 3'd0,
    COME_EVAL  = 3'd1,
    POINT_WAIT = 3'd2,
    POINT_EVAL = 3'd3,
    WIN        = 3'd4,
    LOSE       = 3'd5
  } state_e;

  localparam int unsigned DEF_WIN_A     = 7;
  localparam int unsigned DEF_WIN_B     = 11;
  localparam int unsigned DEF_LOSE_A    = 2;
  localparam int unsigned DEF_LOSE_B    = 3;
  localparam int unsigned DEF_LOSE_C    = 12;
  localparam int unsigned DEF_SEVEN_OUT = 7;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;

  // Bits needed to hold one die value 1..faces.
  function automatic int unsigned dw_f(input int unsigned faces);
    return $clog2(faces + 1);
  endfunction

  // Bits needed to hold the sum of n dice, each up to faces.
  function automatic int unsigned sw_f(input int unsigned n, input int unsigned faces);
    return $clog2(n * faces + 1);
  endfunction

endpackage

// File: rtl/dice_counter.sv
// Free-running odometer of NUM_DICE dice, each counting 1..FACES.
// Die 0 steps every cycle; die k steps when dice 0..k-1 are all at FACES.
// Ports:
//   CLK       clock, rising edge
//   reset     synchronous, active-high; all dice return to 1
//   values_o  current die values, die k at bits [k*DW +: DW]
module dice_counter
  import dice_pkg::*;
#(
  parameter int unsigned NUM_DICE = 2,
  parameter int unsigned FACES    = 6,
  localparam int unsigned DW      = dw_f(FACES)
) (
  input  logic                   CLK,
  input  logic                   reset,
  output logic [NUM_DICE*DW-1:0] values_o
);

  logic [NUM_DICE-1:0][DW-1:0] die_q;
  logic [NUM_DICE-1:0][DW-1:0] die_d;

  // Ripple the wrap condition upward like an odometer carry.
  always_comb begin
    logic run;
    run   = 1'b1;
    die_d = die_q;
    for (int k = 0; k < NUM_DICE; k++) begin
      if (run) begin
        die_d[k] = (die_q[k] == DW'(FACES)) ? DW'(1) : die_q[k] + DW'(1);
      end
      run = run & (die_q[k] == DW'(FACES));
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      die_q <= {NUM_DICE{DW'(1)}};
    end else begin
      die_q <= die_d;
    end
  end

  assign values_o = die_q;

endmodule

// File: rtl/dice_game_n.sv
// Parameterised craps-style dice game. A free-running odometer supplies the
// dice; each rising edge of roll captures them and an FSM applies the
// come-out and point-phase rules. Results are sticky until reset.
// Ports:
//   CLK         clock, rising edge
//   reset       synchronous, active-high
//   roll        roll button (level); each rising edge is one roll request
//   dice        captured die values, die k at bits [k*DW +: DW]
//   sum         sum of captured dice
//   point       established point, 0 when none
//   roll_count  point-phase rolls taken (saturating)
//   ready       block accepts a roll request
//   win, lose   sticky game result
module dice_game_n
  import dice_pkg::*;
#(
  parameter int unsigned NUM_DICE        = 2,
  parameter int unsigned FACES           = 6,
  parameter int unsigned WIN_A           = DEF_WIN_A,
  parameter int unsigned WIN_B           = DEF_WIN_B,
  parameter int unsigned LOSE_A          = DEF_LOSE_A,
  parameter int unsigned LOSE_B          = DEF_LOSE_B,
  parameter int unsigned LOSE_C          = DEF_LOSE_C,
  parameter int unsigned SEVEN_OUT       = DEF_SEVEN_OUT,
  parameter int unsigned MAX_POINT_ROLLS = 0,
  localparam int unsigned DW             = dw_f(FACES),
  localparam int unsigned SW             = sw_f(NUM_DICE, FACES)
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   roll,
  output logic [NUM_DICE*DW-1:0] dice,
  output logic [SW-1:0]          sum,
  output logic [SW-1:0]          point,
  output logic [CNT_W-1:0]       roll_count,
  output logic                   ready,
  output logic                   win,
  output logic                   lose
);

  state_e                 state_q, state_d;
  logic                   roll_q;
  logic                   roll_edge;
  logic [NUM_DICE*DW-1:0] cnt_dice;
  logic [SW-1:0]          roll_sum;
  logic [NUM_DICE*DW-1:0] dice_q, dice_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [SW-1:0]          point_q, point_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ready_q, ready_d;
  logic                   win_q, win_d;
  logic                   lose_q, lose_d;

  dice_counter #(
    .NUM_DICE (NUM_DICE),
    .FACES    (FACES)
  ) u_counter (
    .CLK      (CLK),
    .reset    (reset),
    .values_o (cnt_dice)
  );

  // Follows the button even in reset so a held button cannot roll on release.
  always_ff @(posedge CLK) begin
    roll_q <= roll;
  end

  assign roll_edge = roll & ~roll_q;

  // Sum of the live counters, captured alongside the dice.
  always_comb begin
    roll_sum = '0;
    for (int k = 0; k < NUM_DICE; k++) begin
      roll_sum = roll_sum + SW'(cnt_dice[k*DW +: DW]);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    logic [CNT_W-1:0] count_inc;
    logic             is_win;
    logic             is_lose;

    state_d = state_q;
    dice_d  = dice_q;
    sum_d   = sum_q;
    point_d = point_q;
    count_d = count_q;

    count_inc = (count_q == CNT_W'(CNT_MAX)) ? count_q : count_q + CNT_W'(1);
    // Compare at 32 bits so rule sums beyond the reachable range never alias.
    is_win    = (32'(sum_q) == WIN_A) || (32'(sum_q) == WIN_B);
    is_lose   = (32'(sum_q) == LOSE_A) || (32'(sum_q) == LOSE_B) ||
                (32'(sum_q) == LOSE_C);

    unique case (state_q)
      COME_WAIT, POINT_WAIT: begin
        if (roll_edge) begin
          dice_d  = cnt_dice;
          sum_d   = roll_sum;
          state_d = (state_q == COME_WAIT) ? COME_EVAL : POINT_EVAL;
        end
      end
      COME_EVAL: begin
        if (is_win) begin
          state_d = WIN;
        end else if (is_lose) begin
          state_d = LOSE;
        end else begin
          point_d = sum_q;
          count_d = '0;
          state_d = POINT_WAIT;
        end
      end
      POINT_EVAL: begin
        count_d = count_inc;
        if (sum_q == point_q) begin
          state_d = WIN;
        end else if (32'(sum_q) == SEVEN_OUT) begin
          state_d = LOSE;
        end else if ((MAX_POINT_ROLLS != 0) && (32'(count_inc) == MAX_POINT_ROLLS)) begin
          state_d = LOSE;
        end else begin
          state_d = POINT_WAIT;
        end
      end
      WIN, LOSE: begin
        state_d = state_q;
      end
      default: begin
        state_d = COME_WAIT;
      end
    endcase

    // Flags are registered views of the state being entered.
    ready_d = (state_d == COME_WAIT) || (state_d == POINT_WAIT);
    win_d   = (state_d == WIN);
    lose_d  = (state_d == LOSE);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= COME_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      dice_q  <= '0;
      sum_q   <= '0;
      point_q <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      dice_q  <= dice_d;
      sum_q   <= sum_d;
      point_q <= point_d;
      count_q <= count_d;
      ready_q <= ready_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign dice       = dice_q;
  assign sum        = sum_q;
  assign point      = point_q;
  assign roll_count = count_q;
  assign ready      = ready_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_dice_game_n.sv
// Bench for dice_game_n: default instance, a roll-limited instance sharing its
// roll button, and a 3-die/4-face instance. Die values are predicted from the
// cycle count since reset as base-FACES digits.
module tb_dice_game_n;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       roll_a = 1'b0;
  logic       roll_b = 1'b0;

  logic [5:0] a_dice, l_dice;
  logic [3:0] a_sum, a_point, l_sum, l_point;
  logic [7:0] a_cnt, l_cnt;
  logic       a_rdy, a_win, a_lose, l_rdy, l_win, l_lose;

  logic [8:0] p_dice;
  logic [3:0] p_sum, p_point;
  logic [7:0] p_cnt;
  logic       p_rdy, p_win, p_lose;

  int n_vec = 0;
  int n_err = 0;
  int t;

  always #5 CLK = ~CLK;

  // Cycles since reset release: the odometer is a base-FACES count of this.
  always @(posedge CLK) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  dice_game_n u_dut (
    .CLK(CLK), .reset(reset), .roll(roll_a),
    .dice(a_dice), .sum(a_sum), .point(a_point), .roll_count(a_cnt),
    .ready(a_rdy), .win(a_win), .lose(a_lose)
  );

  dice_game_n #(.MAX_POINT_ROLLS(2)) u_lim (
    .CLK(CLK), .reset(reset), .roll(roll_a),
    .dice(l_dice), .sum(l_sum), .point(l_point), .roll_count(l_cnt),
    .ready(l_rdy), .win(l_win), .lose(l_lose)
  );

  dice_game_n #(.NUM_DICE(3), .FACES(4)) u_p3 (
    .CLK(CLK), .reset(reset), .roll(roll_b),
    .dice(p_dice), .sum(p_sum), .point(p_point), .roll_count(p_cnt),
    .ready(p_rdy), .win(p_win), .lose(p_lose)
  );

  // Game model, one per 2-die instance: index 0 unlimited, index 1 limit 2.
  int         m_lim [2] = '{0, 2};
  logic [5:0] m_dice [2];
  int         m_sum [2];
  int         m_point [2];
  int         m_cnt [2];
  bit         m_win [2];
  bit         m_lose [2];

  function automatic void model_reset();
    for (int g = 0; g < 2; g++) begin
      m_dice[g] = '0; m_sum[g] = 0; m_point[g] = 0; m_cnt[g] = 0;
      m_win[g] = 1'b0; m_lose[g] = 1'b0;
    end
  endfunction

  function automatic void model_roll(int g, int d0, int d1);
    int s;
    if (m_win[g] || m_lose[g]) return;
    s = d0 + d1;
    m_dice[g] = {3'(d1), 3'(d0)};
    m_sum[g] = s;
    if (m_point[g] == 0) begin
      if (s == 7 || s == 11) m_win[g] = 1'b1;
      else if (s == 2 || s == 3 || s == 12) m_lose[g] = 1'b1;
      else begin m_point[g] = s; m_cnt[g] = 0; end
    end else begin
      if (m_cnt[g] < 255) m_cnt[g]++;
      if (s == m_point[g]) m_win[g] = 1'b1;
      else if (s == 7) m_lose[g] = 1'b1;
      else if (m_lim[g] != 0 && m_cnt[g] == m_lim[g]) m_lose[g] = 1'b1;
    end
  endfunction

  function automatic logic [24:0] exp_of(int g);
    return {m_dice[g], 4'(m_sum[g]), 4'(m_point[g]), 8'(m_cnt[g]),
            m_win[g], m_lose[g], !(m_win[g] || m_lose[g])};
  endfunction

  function automatic logic [24:0] obs_of(int g);
    if (g == 0) return {a_dice, a_sum, a_point, a_cnt, a_win, a_lose, a_rdy};
    return {l_dice, l_sum, l_point, l_cnt, l_win, l_lose, l_rdy};
  endfunction

  function automatic logic [8:0] p3_dice(int tt);
    return {3'((tt / 16) % 4 + 1), 3'((tt / 4) % 4 + 1), 3'(tt % 4 + 1)};
  endfunction

  function automatic int p3_sum(int tt);
    return (tt / 16) % 4 + (tt / 4) % 4 + tt % 4 + 3;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; roll_a = 1'b0; roll_b = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    model_reset();
  endtask

  // Press roll_a for h cycles, optionally waiting for dice {w0,w1}; returns
  // at a negedge after evaluation with the button released long enough.
  task automatic press_a(input int h, input int w0, input int w1);
    int guard = 0;
    if (w0 != 0) begin
      while (!((t % 6 + 1) == w0 && ((t / 6) % 6 + 1) == w1)) begin
        @(negedge CLK);
        guard++;
        if (guard > 100) begin
          n_vec++; n_err++;
          $display("FAIL press_wait: dice {%0d,%0d} not seen within 100 cycles", w0, w1);
          return;
        end
      end
    end
    roll_a = 1'b1;
    for (int g = 0; g < 2; g++) model_roll(g, t % 6 + 1, (t / 6) % 6 + 1);
    repeat (h) @(negedge CLK);
    roll_a = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL reset g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
    n_vec++;
    if ({p_dice, p_sum, p_point, p_cnt, p_win, p_lose, p_rdy} !== {9'd0, 4'd0, 4'd0, 8'd0, 3'b001}) begin
      n_err++; $display("FAIL reset_p3: got dice=%h sum=%0d rdy=%b", p_dice, p_sum, p_rdy);
    end
  endtask

  task automatic test_come_win();
    do_reset();
    press_a(1, 3, 4);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL come_win g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
  endtask

  task automatic test_come_lose();
    do_reset();
    press_a(2, 1, 1);
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < 2; g++) begin
        n_vec++;
        if (obs_of(g) !== exp_of(g)) begin
          n_err++; $display("FAIL come_lose r%0d g%0d: got %h want %h", r, g, obs_of(g), exp_of(g));
        end
      end
      press_a(1, 0, 0);
    end
  endtask

  task automatic test_point_made();
    do_reset();
    press_a(1, 2, 2);
    press_a(1, 1, 2);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL point_mid g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
    press_a(1, 1, 3);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL point_made g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
  endtask

  task automatic test_seven_out();
    do_reset();
    press_a(1, 2, 3);
    press_a(3, 3, 4);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL seven_out g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
  endtask

  task automatic test_roll_limit();
    do_reset();
    press_a(1, 3, 3);
    press_a(1, 1, 1);
    press_a(1, 4, 4);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL roll_limit g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
  endtask

  task automatic test_param();
    int tl [10] = '{0, 3, 4, 15, 16, 63, 0, 0, 0, 0};
    int guard;
    for (int i = 6; i < 10; i++) tl[i] = int'($urandom_range(0, 80));
    for (int i = 0; i < 10; i++) begin
      do_reset();
      guard = 0;
      while (t != tl[i] && guard < 200) begin @(negedge CLK); guard++; end
      roll_b = 1'b1;
      @(negedge CLK);
      roll_b = 1'b0;
      @(negedge CLK);
      n_vec++;
      if (p_dice !== p3_dice(tl[i]) || p_sum !== 4'(p3_sum(tl[i]))) begin
        n_err++;
        $display("FAIL p3_capture T=%0d: got dice=%h sum=%0d want dice=%h sum=%0d",
                 tl[i], p_dice, p_sum, p3_dice(tl[i]), p3_sum(tl[i]));
      end
      n_vec++;
      if (p_win !== (p3_sum(tl[i]) == 7 || p3_sum(tl[i]) == 11) ||
          p_lose !== (p3_sum(tl[i]) == 2 || p3_sum(tl[i]) == 3 || p3_sum(tl[i]) == 12)) begin
        n_err++; $display("FAIL p3_result T=%0d: got win=%b lose=%b", tl[i], p_win, p_lose);
      end
    end
    // Button held for 20 cycles: one capture that sets a point, nothing more.
    do_reset();
    guard = 0;
    while ((p3_sum(t) inside {2, 3, 7, 11, 12}) && guard < 100) begin @(negedge CLK); guard++; end
    tl[0] = t;
    roll_b = 1'b1;
    repeat (20) @(negedge CLK);
    roll_b = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (p_dice !== p3_dice(tl[0]) || p_point !== 4'(p3_sum(tl[0])) || p_cnt !== 8'd0 || p_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL p3_held: got dice=%h point=%0d cnt=%0d rdy=%b want dice=%h point=%0d cnt=0 rdy=1",
               p_dice, p_point, p_cnt, p_rdy, p3_dice(tl[0]), p3_sum(tl[0]));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_a(1, 3, 3);
    roll_a = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    model_reset();
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL reset_mid g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL reset_held_roll g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
    roll_a = 1'b0;
    @(negedge CLK);
    press_a(1, 0, 0);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (obs_of(g) !== exp_of(g)) begin
        n_err++; $display("FAIL reset_repress g%0d: got %h want %h", g, obs_of(g), exp_of(g));
      end
    end
  endtask

  task automatic test_random();
    for (int gm = 0; gm < 25; gm++) begin
      do_reset();
      for (int r = 0; r < 10; r++) begin
        repeat ($urandom_range(0, 12)) @(negedge CLK);
        press_a(int'($urandom_range(1, 4)), 0, 0);
        for (int g = 0; g < 2; g++) begin
          n_vec++;
          if (obs_of(g) !== exp_of(g)) begin
            n_err++;
            $display("FAIL random gm%0d r%0d g%0d: got %h want %h", gm, r, g, obs_of(g), exp_of(g));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_come_win();
    test_come_lose();
    test_point_made();
    test_seven_out();
    test_roll_limit();
    test_param();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
